// File: rtl/data_sram_bridge.sv
// -----------------------------------------------------------------------------
// data_sram_bridge
//
// Bridges the CPU core's data-memory port to an external asynchronous SRAM.
// Each accepted request becomes one SRAM cycle with the following phases:
//   SETUP  : one cycle with address/data/ce_n driven and both strobes high.
//   ACCESS : WAIT_CYCLES cycles with the strobe low (oe_n for read, we_n for
//            write).
//   DONE   : one cycle with both strobes high and ce_n/data still driven
//            (hold time). cpu_ready_o pulses for this cycle.
// The core's MEM stage stays stalled until the ready pulse.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   cpu_ce_i         request valid (held by the core until cpu_ready_o)
//   cpu_we_i         1 = write, 0 = read
//   cpu_sel_i        byte enables, bit3 = data[31:24]
//   cpu_addr_i       byte address, bits [SRAM_AW+1:2] form the word address
//   cpu_data_i       write data
//   cpu_data_o       read data, held until the next read completes
//   cpu_ready_o      one-cycle completion pulse
//   sram_addr_o      SRAM word address
//   sram_data_o      write data to pads
//   sram_data_oe_o   pad output enable for write data
//   sram_data_i      read data from pads
//   sram_ce_n_o      chip enable, active-low
//   sram_oe_n_o      output enable, active-low
//   sram_we_n_o      write enable, active-low
//   sram_be_n_o      byte enables, active-low
// -----------------------------------------------------------------------------
module data_sram_bridge #(
    parameter int WAIT_CYCLES = 2,  // strobe low time, legal range 1..15
    parameter int SRAM_AW     = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cpu_ce_i,
    input  logic               cpu_we_i,
    input  logic [3:0]         cpu_sel_i,
    input  logic [31:0]        cpu_addr_i,
    input  logic [31:0]        cpu_data_i,
    output logic [31:0]        cpu_data_o,
    output logic               cpu_ready_o,
    output logic [SRAM_AW-1:0] sram_addr_o,
    output logic [31:0]        sram_data_o,
    output logic               sram_data_oe_o,
    input  logic [31:0]        sram_data_i,
    output logic               sram_ce_n_o,
    output logic               sram_oe_n_o,
    output logic               sram_we_n_o,
    output logic [3:0]         sram_be_n_o
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        DONE
    } state_t;

    // Counter runs WAIT_CYCLES-1 down to 0, so ACCESS lasts WAIT_CYCLES cycles.
    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 we_q, we_d;
    logic [31:0]          cpu_data_q, cpu_data_d;
    logic                 ready_q, ready_d;
    logic [SRAM_AW-1:0]   addr_q, addr_d;
    logic [31:0]          wdata_q, wdata_d;
    logic                 data_oe_q, data_oe_d;
    logic                 ce_n_q, ce_n_d;
    logic                 oe_n_q, oe_n_d;
    logic                 we_n_q, we_n_d;
    logic [3:0]           be_n_q, be_n_d;

    // Address bits outside the SRAM word range are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{cpu_addr_i[31:SRAM_AW+2], cpu_addr_i[1:0]};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            we_q       <= 1'b0;
            cpu_data_q <= '0;
            ready_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            data_oe_q  <= 1'b0;
            ce_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            be_n_q     <= 4'hF;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            we_q       <= we_d;
            cpu_data_q <= cpu_data_d;
            ready_q    <= ready_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            data_oe_q  <= data_oe_d;
            ce_n_q     <= ce_n_d;
            oe_n_q     <= oe_n_d;
            we_n_q     <= we_n_d;
            be_n_q     <= be_n_d;
        end
    end

    // All SRAM-side outputs are computed here as next-state values and then
    // registered, so no cpu_* input reaches a pad combinationally.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned, which would infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        cpu_data_d = cpu_data_q;
        ready_d    = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        data_oe_d  = data_oe_q;
        ce_n_d     = ce_n_q;
        oe_n_d     = oe_n_q;
        we_n_d     = we_n_q;
        be_n_d     = be_n_q;

        case (state_q)
            IDLE: begin
                if (cpu_ce_i) begin
                    we_d    = cpu_we_i;
                    addr_d  = cpu_addr_i[SRAM_AW+1:2];
                    be_n_d  = ~cpu_sel_i;
                    ce_n_d  = 1'b0;
                    if (cpu_we_i) begin
                        wdata_d   = cpu_data_i;
                        data_oe_d = 1'b1;
                    end
                    state_d = SETUP;
                end
            end
            SETUP: begin
                cnt_d = CNT_LOAD;
                // The strobe goes low as ACCESS is entered.
                if (we_q) we_n_d = 1'b0;
                else      oe_n_d = 1'b0;
                state_d = ACCESS;
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    oe_n_d  = 1'b1;
                    we_n_d  = 1'b1;
                    ready_d = 1'b1;
                    // Sample the pads while oe_n is still low.
                    if (!we_q) cpu_data_d = sram_data_i;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                ce_n_d    = 1'b1;
                data_oe_d = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign cpu_data_o     = cpu_data_q;
    assign cpu_ready_o    = ready_q;
    assign sram_addr_o    = addr_q;
    assign sram_data_o    = wdata_q;
    assign sram_data_oe_o = data_oe_q;
    assign sram_ce_n_o    = ce_n_q;
    assign sram_oe_n_o    = oe_n_q;
    assign sram_we_n_o    = we_n_q;
    assign sram_be_n_o    = be_n_q;

endmodule

// File: tb/tb_data_sram_bridge.sv
// -----------------------------------------------------------------------------
// tb_data_sram_bridge
//
// Directed bench for data_sram_bridge (WAIT_CYCLES=2). A small behavioural
// asynchronous SRAM model sits on the pad side; writes land on the rising edge
// of we_n with the byte enables applied, reads drive the array word while
// ce_n and oe_n are both low.
// -----------------------------------------------------------------------------
module tb_data_sram_bridge;

    logic        clk;
    logic        rst;
    logic        cpu_ce_i;
    logic        cpu_we_i;
    logic [3:0]  cpu_sel_i;
    logic [31:0] cpu_addr_i;
    logic [31:0] cpu_data_i;
    logic [31:0] cpu_data_o;
    logic        cpu_ready_o;
    logic [19:0] sram_addr_o;
    logic [31:0] sram_data_o;
    logic        sram_data_oe_o;
    logic [31:0] sram_data_i;
    logic        sram_ce_n_o;
    logic        sram_oe_n_o;
    logic        sram_we_n_o;
    logic [3:0]  sram_be_n_o;

    int errors = 0;
    int checks = 0;

    data_sram_bridge #(
        .WAIT_CYCLES(2),
        .SRAM_AW    (20)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cpu_ce_i      (cpu_ce_i),
        .cpu_we_i      (cpu_we_i),
        .cpu_sel_i     (cpu_sel_i),
        .cpu_addr_i    (cpu_addr_i),
        .cpu_data_i    (cpu_data_i),
        .cpu_data_o    (cpu_data_o),
        .cpu_ready_o   (cpu_ready_o),
        .sram_addr_o   (sram_addr_o),
        .sram_data_o   (sram_data_o),
        .sram_data_oe_o(sram_data_oe_o),
        .sram_data_i   (sram_data_i),
        .sram_ce_n_o   (sram_ce_n_o),
        .sram_oe_n_o   (sram_oe_n_o),
        .sram_we_n_o   (sram_we_n_o),
        .sram_be_n_o   (sram_be_n_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- SRAM model ----------------
    logic [31:0] mem [0:4095];

    assign sram_data_i = (sram_ce_n_o === 1'b0 && sram_oe_n_o === 1'b0)
                         ? mem[sram_addr_o[11:0]] : 32'hxxxx_xxxx;

    always @(posedge sram_we_n_o) begin
        if (sram_ce_n_o === 1'b0 && rst === 1'b0) begin
            for (int b = 0; b < 4; b++) begin
                if (!sram_be_n_o[b])
                    mem[sram_addr_o[11:0]][8*b +: 8] = sram_data_o[8*b +: 8];
            end
        end
    end

    // ---------------- monitors ----------------
    int cyc = 0;
    int we_low_cnt = 0;
    int oe_low_cnt = 0;
    int ready_cnt = 0;
    int last_ready_cyc = 0;
    int prev_ready_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (sram_we_n_o === 1'b0) we_low_cnt <= we_low_cnt + 1;
        if (sram_oe_n_o === 1'b0) oe_low_cnt <= oe_low_cnt + 1;
        if (cpu_ready_o === 1'b1) begin
            ready_cnt      <= ready_cnt + 1;
            prev_ready_cyc <= last_ready_cyc;
            last_ready_cyc <= cyc;
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic we, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] sel);
        cpu_ce_i   = 1'b1;
        cpu_we_i   = we;
        cpu_addr_i = addr;
        cpu_data_i = data;
        cpu_sel_i  = sel;
    endtask

    // Pad-side strobe snapshot: {ce_n, oe_n, we_n, data_oe, ready}
    function automatic logic [31:0] strobes();
        return {27'd0, sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_data_oe_o, cpu_ready_o};
    endfunction

    int base_we, base_oe, base_rdy;

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        rst        = 1'b1;
        cpu_ce_i   = 1'b0;
        cpu_we_i   = 1'b0;
        cpu_sel_i  = 4'h0;
        cpu_addr_i = 32'h0;
        cpu_data_i = 32'h0;

        // ---- reset values ----
        #1;
        check("rst_strobes", strobes(), 32'b11100);
        check("rst_be_n", {28'd0, sram_be_n_o}, 32'hF);
        check("rst_addr", {12'd0, sram_addr_o}, 32'h0);
        check("rst_wdata", sram_data_o, 32'h0);
        check("rst_cpu_data", cpu_data_o, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // ---- 1: idle for 20 cycles ----
        base_rdy = ready_cnt;
        repeat (20) tick();
        check("idle_ready_cnt", ready_cnt - base_rdy, 0);
        check("idle_strobes", strobes(), 32'b11100);

        // ---- 2: full-word write ----
        base_we = we_low_cnt; base_oe = oe_low_cnt; base_rdy = ready_cnt;
        request(1'b1, 32'h0000_1234, 32'hDEAD_BEEF, 4'b1111);
        tick(); // SETUP
        check("wr_setup_addr", {12'd0, sram_addr_o}, 32'h0048D);
        check("wr_setup_wdata", sram_data_o, 32'hDEAD_BEEF);
        check("wr_setup_strobes", strobes(), 32'b01110);
        check("wr_setup_be_n", {28'd0, sram_be_n_o}, 32'h0);
        tick(); // ACCESS 1
        check("wr_acc1_strobes", strobes(), 32'b01010);
        tick(); // ACCESS 2
        check("wr_acc2_strobes", strobes(), 32'b01010);
        tick(); // DONE
        check("wr_done_strobes", strobes(), 32'b01111);
        cpu_ce_i = 1'b0;
        tick(); // IDLE
        check("wr_idle_strobes", strobes(), 32'b11100);
        check("wr_we_low_cycles", we_low_cnt - base_we, 2);
        check("wr_oe_low_cycles", oe_low_cnt - base_oe, 0);
        check("wr_ready_pulses", ready_cnt - base_rdy, 1);
        check("wr_mem", mem[12'h48D], 32'hDEAD_BEEF);
        check("wr_cpu_data_kept", cpu_data_o, 32'h0);

        // ---- 3: full-word read ----
        mem[12'h48D] = 32'hCAFE_F00D;
        base_we = we_low_cnt; base_oe = oe_low_cnt;
        request(1'b0, 32'h0000_1234, 32'h0, 4'b1111);
        tick(); // SETUP
        check("rd_setup_strobes", strobes(), 32'b01100);
        tick(); // ACCESS 1
        check("rd_acc1_strobes", strobes(), 32'b00100);
        tick(); // ACCESS 2
        check("rd_acc2_strobes", strobes(), 32'b00100);
        tick(); // DONE
        check("rd_done_strobes", strobes(), 32'b01101);
        check("rd_done_data", cpu_data_o, 32'hCAFE_F00D);
        cpu_ce_i = 1'b0;
        tick();
        tick();
        check("rd_data_held", cpu_data_o, 32'hCAFE_F00D);
        check("rd_ready_low", {31'd0, cpu_ready_o}, 32'h0);
        check("rd_oe_low_cycles", oe_low_cnt - base_oe, 2);
        check("rd_we_low_cycles", we_low_cnt - base_we, 0);

        // ---- 4: byte write, sel=0100 ----
        mem[12'h100] = 32'h1122_3344;
        request(1'b1, 32'h0000_0400, 32'hAABB_CCDD, 4'b0100);
        tick(); // SETUP
        check("bw_setup_be_n", {28'd0, sram_be_n_o}, 32'hB);
        tick();
        tick();
        tick(); // DONE
        check("bw_done_be_n", {28'd0, sram_be_n_o}, 32'hB);
        check("bw_done_ready", {31'd0, cpu_ready_o}, 32'h1);
        cpu_ce_i = 1'b0;
        tick();
        check("bw_mem", mem[12'h100], 32'h11BB_3344);
        check("bw_cpu_data_kept", cpu_data_o, 32'hCAFE_F00D);

        // ---- 5: back-to-back reads, address changed mid-access ----
        mem[12'h200] = 32'h0101_0101;
        mem[12'h201] = 32'h0202_0202;
        base_rdy = ready_cnt;
        request(1'b0, 32'h0000_0800, 32'h0, 4'b1111);
        tick(); // SETUP
        check("b2b_addr0", {12'd0, sram_addr_o}, 32'h00200);
        cpu_addr_i = 32'h0000_0804;
        tick(); // ACCESS 1
        check("b2b_addr0_stable", {12'd0, sram_addr_o}, 32'h00200);
        tick(); // ACCESS 2
        tick(); // DONE
        check("b2b_data0", cpu_data_o, 32'h0101_0101);
        tick(); // IDLE, ce still high -> accepted
        check("b2b_gap_strobes", strobes(), 32'b11100);
        tick(); // SETUP
        check("b2b_addr1", {12'd0, sram_addr_o}, 32'h00201);
        tick();
        tick();
        tick(); // DONE
        check("b2b_data1", cpu_data_o, 32'h0202_0202);
        cpu_ce_i = 1'b0;
        tick();
        check("b2b_ready_pulses", ready_cnt - base_rdy, 2);
        check("b2b_ready_spacing", last_ready_cyc - prev_ready_cyc, 5);

        // ---- 6: reset during a write's ACCESS phase ----
        base_rdy = ready_cnt;
        request(1'b1, 32'h0000_0C00, 32'h5555_5555, 4'b1111);
        tick(); // SETUP
        tick(); // ACCESS 1
        check("rst_mid_we_low", {31'd0, sram_we_n_o}, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_strobes", strobes(), 32'b11100);
        check("rst_mid_cpu_data", cpu_data_o, 32'h0);
        cpu_ce_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) tick();
        check("rst_mid_no_ready", ready_cnt - base_rdy, 0);
        check("rst_mid_idle", strobes(), 32'b11100);

        request(1'b0, 32'h0000_1234, 32'h0, 4'b1111);
        tick(); // SETUP
        tick();
        tick();
        tick(); // DONE
        check("post_rst_ready", {31'd0, cpu_ready_o}, 32'h1);
        check("post_rst_data", cpu_data_o, 32'hCAFE_F00D);
        cpu_ce_i = 1'b0;
        tick();
        check("post_rst_idle", strobes(), 32'b11100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
